// File: rtl/ca_scroll_renderer.sv
// Elementary cellular-automaton renderer: one CA generation per cell row, optional per-frame scroll.
// Latency: 1 clk from beam position to cell_out_o/color_out_o.
// Backpressure: none, follows the free-running pixel stream.
module ca_scroll_renderer #(
    parameter int GRID_W   = 160,
    parameter int LOG_CELL = 2,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         pix_x_i,
    input  logic [9:0]         pix_y_i,
    input  logic               video_active_i,
    input  logic [7:0]         rule_i,
    input  logic               rule_load_i,
    input  logic               wrap_en_i,
    input  logic [1:0]         seed_sel_i,
    input  logic               reseed_i,
    input  logic               scroll_en_i,
    input  logic [COLOR_W-1:0] fg_color_i,
    output logic               cell_out_o,
    output logic [COLOR_W-1:0] color_out_o
);

    localparam int         PAD      = (H_ACTIVE - (GRID_W << LOG_CELL)) / 2;
    localparam logic [9:0] PAD_X    = 10'(PAD);
    localparam logic [9:0] GRID_N   = 10'(GRID_W);
    localparam logic [9:0] LAST_IDX = 10'(GRID_W - 1);
    localparam logic [9:0] V_END    = 10'(V_ACTIVE);
    localparam logic [9:0] SCROLL_Y = 10'(1 << LOG_CELL);

    logic [GRID_W-1:0]  cur_row_q, cur_row_d, top_row_q, top_row_d, next_row_q, next_row_d;
    logic               hold_q, hold_d, prev_c_q, prev_c_d, cell0_q, cell0_d;
    logic [7:0]         rule_q, rule_d, rule_nxt_q, rule_nxt_d;
    logic               rule_pend_q, rule_pend_d, reseed_pend_q, reseed_pend_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_w;
    logic [GRID_W-1:0]  seed_row;
    logic               cell_q, cell_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic [9:0] rel_x, idx;
    logic       in_grid, cell_en, frame_edge, line0, compute;
    logic       nb_l, nb_r, new_cell;

    // Pixels left of the grid wrap rel_x to a large value, so one compare covers both sides.
    assign rel_x      = pix_x_i - PAD_X;
    assign idx        = rel_x >> LOG_CELL;
    assign in_grid    = video_active_i && (idx < GRID_N) && (pix_y_i < V_END);
    assign cell_en    = in_grid && (rel_x[LOG_CELL-1:0] == '0);
    assign frame_edge = (pix_x_i == '0) && (pix_y_i == V_END);
    assign line0      = (pix_y_i == '0);
    assign compute    = (pix_y_i[LOG_CELL-1:0] == '0) && !line0;

    // cur_row_q[0] is this cell of the previous row; cell 0 is overwritten by the time the last cell needs it.
    assign nb_l = (idx == '0)      ? (wrap_en_i & cur_row_q[GRID_W-1]) : prev_c_q;
    assign nb_r = (idx == LAST_IDX) ? (wrap_en_i & cell0_q)            : cur_row_q[1];

    always_comb begin
        new_cell = cur_row_q[0];
        if (line0)
            new_cell = top_row_q[0];
        else if (compute)
            new_cell = rule_q[{nb_l, cur_row_q[0], nb_r}];
    end

    always_comb begin
        seed_row = '0;
        lfsr_w   = lfsr_q;
        case (seed_sel_i)
            2'b00: seed_row[GRID_W/2] = 1'b1;
            2'b01: seed_row[0] = 1'b1;
            2'b10: begin
                for (int i = 0; i < GRID_W; i++) begin
                    seed_row[i] = lfsr_w[0];
                    lfsr_w = {lfsr_w[0] ^ lfsr_w[2] ^ lfsr_w[3] ^ lfsr_w[5], lfsr_w[15:1]};
                end
            end
            default: seed_row = '0;
        endcase
    end

    always_comb begin
        cur_row_d     = cur_row_q;
        top_row_d     = top_row_q;
        next_row_d    = next_row_q;
        hold_d        = hold_q;
        prev_c_d      = prev_c_q;
        cell0_d       = cell0_q;
        rule_d        = rule_q;
        rule_nxt_d    = rule_nxt_q;
        rule_pend_d   = rule_pend_q;
        reseed_pend_d = reseed_pend_q;
        lfsr_d        = lfsr_q;
        if (cell_en) begin
            cur_row_d = {new_cell, cur_row_q[GRID_W-1:1]};
            hold_d    = new_cell;
            prev_c_d  = cur_row_q[0];
            if (idx == '0)
                cell0_d = cur_row_q[0];
            if (line0)
                top_row_d = {top_row_q[0], top_row_q[GRID_W-1:1]};
            if (pix_y_i == SCROLL_Y)
                next_row_d = {new_cell, next_row_q[GRID_W-1:1]};
        end
        if (frame_edge) begin
            if (rule_pend_q) begin
                rule_d      = rule_nxt_q;
                rule_pend_d = 1'b0;
            end
            if (reseed_pend_q) begin
                top_row_d     = seed_row;
                reseed_pend_d = 1'b0;
                if (seed_sel_i == 2'b10)
                    lfsr_d = lfsr_w;
            end else if (scroll_en_i) begin
                top_row_d = next_row_q;
            end
        end
        // Requests arriving on the boundary cycle stay pending for the following frame.
        if (rule_load_i) begin
            rule_nxt_d  = rule_i;
            rule_pend_d = 1'b1;
        end
        if (reseed_i)
            reseed_pend_d = 1'b1;
        cell_d  = in_grid && (cell_en ? new_cell : hold_q);
        color_d = cell_d ? fg_color_i : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_row_q     <= '0;
            top_row_q     <= '0;
            next_row_q    <= '0;
            hold_q        <= 1'b0;
            prev_c_q      <= 1'b0;
            cell0_q       <= 1'b0;
            rule_q        <= 8'd30;
            rule_nxt_q    <= 8'd30;
            rule_pend_q   <= 1'b0;
            reseed_pend_q <= 1'b1;
            lfsr_q        <= 16'hACE1;
            cell_q        <= 1'b0;
            color_q       <= '0;
        end else begin
            cur_row_q     <= cur_row_d;
            top_row_q     <= top_row_d;
            next_row_q    <= next_row_d;
            hold_q        <= hold_d;
            prev_c_q      <= prev_c_d;
            cell0_q       <= cell0_d;
            rule_q        <= rule_d;
            rule_nxt_q    <= rule_nxt_d;
            rule_pend_q   <= rule_pend_d;
            reseed_pend_q <= reseed_pend_d;
            lfsr_q        <= lfsr_d;
            cell_q        <= cell_d;
            color_q       <= color_d;
        end
    end

    assign cell_out_o  = cell_q;
    assign color_out_o = color_q;

endmodule

// File: tb/tb_ca_scroll_renderer.sv
// Directed bench for ca_scroll_renderer on a reduced 16-cell grid, 2x2-pixel cells, 40x12 visible raster.
module tb_ca_scroll_renderer;

    localparam int GW = 16, LC = 1, HA = 40, VA = 12, HT = 44, VT = 14;
    localparam int PADB = (HA - (GW << LC)) / 2;
    localparam logic [5:0] FG = 6'h2A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_active = 1'b0;
    logic [7:0]  rule_in = 8'd0;
    logic        rule_load = 1'b0, wrap_en = 1'b0, reseed = 1'b0, scroll_en = 1'b0;
    logic [1:0]  seed_sel = 2'b00;
    logic [5:0]  fg_color = FG;
    logic        cell_out;
    logic [5:0]  color_out;

    int n_chk = 0, n_pass = 0;
    int rl_y = -1, rl_x = 0, rs_y = -1, rs_x = 0, rst_y = -1, rst_x = 0;
    logic [7:0] rl_val = 8'd0;
    logic       cap_cell [0:VT-1][0:HT-1];
    logic [5:0] cap_col  [0:VT-1][0:HT-1];

    always #5 clk = ~clk;

    ca_scroll_renderer #(.GRID_W(GW), .LOG_CELL(LC), .H_ACTIVE(HA), .V_ACTIVE(VA), .COLOR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .pix_x_i(pix_x), .pix_y_i(pix_y), .video_active_i(video_active),
        .rule_i(rule_in), .rule_load_i(rule_load), .wrap_en_i(wrap_en), .seed_sel_i(seed_sel),
        .reseed_i(reseed), .scroll_en_i(scroll_en), .fg_color_i(fg_color),
        .cell_out_o(cell_out), .color_out_o(color_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One frame starting on the boundary cycle (first blanking line), then visible lines 0..VA-1.
    task automatic run_frame();
        int y;
        for (int k = 0; k < VT; k++) begin
            y = (k + VA) % VT;
            for (int x = 0; x < HT; x++) begin
                pix_x        = 10'(x);
                pix_y        = 10'(y);
                video_active = (x < HA) && (y < VA);
                rule_load    = (y == rl_y) && (x == rl_x);
                rule_in      = rl_val;
                reseed       = (y == rs_y) && (x == rs_x);
                rst_n        = !((y == rst_y) && (x >= rst_x) && (x < rst_x + 3));
                @(posedge clk);
                #1;
                cap_cell[y][x] = cell_out;
                cap_col[y][x]  = color_out;
            end
        end
        rl_y = -1; rs_y = -1; rst_y = -1;
        rule_load = 1'b0; reseed = 1'b0; rst_n = 1'b1;
    endtask

    function automatic logic [GW-1:0] line_cells(input int y);
        logic [GW-1:0] r;
        for (int i = 0; i < GW; i++) r[i] = cap_cell[y][PADB + 2*i];
        return r;
    endfunction

    // Every pixel must match its cell-row's first line, be zero outside the grid, and colour must track cell.
    function automatic int frame_errors();
        int errs = 0;
        logic e;
        logic [GW-1:0] r;
        for (int y = 0; y < VT; y++) begin
            r = (y < VA) ? line_cells(y & ~1) : '0;
            for (int x = 0; x < HT; x++) begin
                e = (y < VA) && (x >= PADB) && (x < PADB + 2*GW) && r[(x - PADB) / 2];
                if (cap_cell[y][x] !== e) errs++;
                if (cap_col[y][x] !== (e ? FG : 6'h00)) errs++;
            end
        end
        return errs;
    endfunction

    function automatic logic [GW-1:0] next_gen(input logic [GW-1:0] r, input logic [7:0] rule, input logic wrap);
        logic [GW-1:0] n;
        logic l, c, rr;
        for (int i = 0; i < GW; i++) begin
            if (i == 0) l = wrap & r[GW-1]; else l = r[i-1];
            if (i == GW-1) rr = wrap & r[0]; else rr = r[i+1];
            c = r[i];
            n[i] = rule[{l, c, rr}];
        end
        return n;
    endfunction

    function automatic logic [GW-1:0] lfsr_seed();
        logic [15:0] l = 16'hACE1;
        logic [GW-1:0] s;
        for (int i = 0; i < GW; i++) begin
            s[i] = l[0];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        return s;
    endfunction

    initial begin
        logic [GW-1:0] prev, seed;
        int live;
        rst_n = 1'b0;
        pix_x = 10'(PADB + 2*(GW/2)); pix_y = '0; video_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_cell", 32'(cell_out), 32'd0);
        chk("rst_color", 32'(color_out), 32'd0);
        rst_n = 1'b1;

        // Frame 1: centre seed, rule 30, zero boundary; rule 90 queued mid-frame.
        rl_y = 5; rl_x = 7; rl_val = 8'd90;
        run_frame();
        chk("f1_row0", 32'(line_cells(0)), 32'h0100);
        chk("f1_row1", 32'(line_cells(2)), 32'h0380);
        chk("f1_row2", 32'(line_cells(4)), 32'h04C0);
        chk("f1_live_px", 32'(cap_col[1][PADB + 17]), 32'(FG));
        chk("f1_dead_px", 32'(cap_col[0][PADB + 15]), 32'd0);
        chk("f1_blank_px", 32'(cap_col[0][HA + 1]), 32'd0);
        chk("f1_consist", 32'(frame_errors()), 32'd0);

        // Frame 2: rule 90 now active; queue rule 30 and a reseed for frame 3.
        rl_y = 3; rl_x = 10; rl_val = 8'd30; rs_y = 4; rs_x = 2;
        run_frame();
        chk("f2_row0", 32'(line_cells(0)), 32'h0100);
        chk("f2_row1_r90", 32'(line_cells(2)), 32'h0280);
        chk("f2_consist", 32'(frame_errors()), 32'd0);

        seed_sel = 2'b01; wrap_en = 1'b1;
        run_frame();
        chk("f3_row0", 32'(line_cells(0)), 32'h0001);
        chk("f3_row1_wrap", 32'(line_cells(2)), 32'h8003);
        chk("f3_consist", 32'(frame_errors()), 32'd0);

        wrap_en = 1'b0;
        run_frame();
        chk("f4_row0", 32'(line_cells(0)), 32'h0001);
        chk("f4_row1_nowrap", 32'(line_cells(2)), 32'h0003);
        prev = line_cells(2);

        scroll_en = 1'b1;
        for (int f = 5; f <= 7; f++) begin
            run_frame();
            chk($sformatf("f%0d_scroll_row0", f), 32'(line_cells(0)), 32'(prev));
            chk($sformatf("f%0d_scroll_row1", f), 32'(line_cells(2)), 32'(next_gen(line_cells(0), 8'd30, 1'b0)));
            prev = line_cells(2);
        end
        chk("f5_7_moved", 32'(prev != 16'h0003), 32'd1);

        // Reseed to all-zero for frame 8 (requested during frame 7 would have been cleaner; pulse now lands in frame 8 boundary via pending).
        scroll_en = 1'b0; seed_sel = 2'b11;
        rs_y = VA; rs_x = 0;
        run_frame();
        run_frame();
        live = 0;
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++)
                if (cap_col[y][x] != 6'h00 || cap_cell[y][x] != 1'b0) live++;
        chk("f9_all_zero", 32'(live), 32'd0);

        rs_y = 6; rs_x = 3;
        run_frame();
        seed_sel = 2'b10;
        run_frame();
        seed = lfsr_seed();
        chk("lfsr_row0", 32'(line_cells(0)), 32'(seed));
        chk("lfsr_row1", 32'(line_cells(2)), 32'(next_gen(seed, 8'd30, 1'b0)));
        chk("lfsr_consist", 32'(frame_errors()), 32'd0);

        // rule_load on the boundary cycle itself only takes effect one frame later.
        rl_y = VA; rl_x = 0; rl_val = 8'd90;
        run_frame();
        chk("edge_load_same", 32'(line_cells(2)), 32'(next_gen(seed, 8'd30, 1'b0)));
        run_frame();
        chk("edge_load_next", 32'(line_cells(2)), 32'(next_gen(seed, 8'd90, 1'b0)));
        chk("edge_load_row0", 32'(line_cells(0)), 32'(seed));

        // Mid-frame reset on the second pixel of a live seed cell on a copy line.
        live = 0;
        for (int i = GW - 1; i >= 0; i--) if (seed[i]) live = i;
        seed_sel = 2'b00;
        rst_y = 1; rst_x = PADB + 2*live + 1;
        run_frame();
        chk("rst_pre_live", 32'(cap_col[1][PADB + 2*live]), 32'(FG));
        chk("rst_mid_color", 32'(cap_col[1][PADB + 2*live + 1]), 32'd0);
        chk("rst_mid_cell", 32'(cap_cell[1][PADB + 2*live + 1]), 32'd0);
        run_frame();
        chk("post_rst_row0", 32'(line_cells(0)), 32'h0100);
        chk("post_rst_row1", 32'(line_cells(2)), 32'h0380);
        chk("post_rst_consist", 32'(frame_errors()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
